// File: rtl/axi_xbar_map_ctrl_if.sv
// Configuration bus and per-port handshake observation bundle for the crossbar map controller.
`timescale 1ns/1ps
interface axi_xbar_map_ctrl_if #(
    parameter int NoSlvPorts = 2,
    parameter int NoRules    = 4
);
    logic                      cfg_valid_i;
    logic                      cfg_ready_o;
    logic [15:0]               cfg_addr_i;
    logic [31:0]               cfg_wdata_i;
    logic [NoSlvPorts-1:0]     aw_fire_i;
    logic [NoSlvPorts-1:0]     ar_fire_i;
    logic [NoSlvPorts-1:0]     b_fire_i;
    logic [NoSlvPorts-1:0]     r_last_fire_i;
    logic [NoSlvPorts-1:0]     gate_o;
    logic [NoRules*160-1:0]    addr_map_o;
    logic [NoSlvPorts-1:0]     en_default_o;
    logic                      busy_o;
    logic                      commit_done_o;
    logic                      err_o;

    modport slv (
        input  cfg_valid_i, cfg_addr_i, cfg_wdata_i,
        input  aw_fire_i, ar_fire_i, b_fire_i, r_last_fire_i,
        output cfg_ready_o, gate_o, addr_map_o, en_default_o,
        output busy_o, commit_done_o, err_o
    );

    modport mst (
        output cfg_valid_i, cfg_addr_i, cfg_wdata_i,
        output aw_fire_i, ar_fire_i, b_fire_i, r_last_fire_i,
        input  cfg_ready_o, gate_o, addr_map_o, en_default_o,
        input  busy_o, commit_done_o, err_o
    );
endinterface

// File: rtl/axi_xbar_map_ctrl.sv
// Shadow/active crossbar address map with a drain-then-swap commit sequence.
// Decoders only ever see the active copy, which changes while no transaction is in flight.
`timescale 1ns/1ps
module axi_xbar_map_ctrl #(
    parameter int NoSlvPorts = 2,
    parameter int NoRules    = 4,
    parameter int MaxTxns    = 8,
    parameter int CntW       = $clog2(MaxTxns + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    axi_xbar_map_ctrl_if.slv bus
);
    localparam int              RuleW      = 160;
    localparam int              MapW       = NoRules * RuleW;
    localparam logic [15:0]     MaskAddr   = 16'(NoRules * 8);
    localparam logic [15:0]     CommitAddr = 16'(NoRules * 8 + 1);
    localparam int              CntMax     = (1 << CntW) - 1;
    localparam logic [CntW-1:0] GateThr    = CntW'(MaxTxns - 2);

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_e;

    state_e                state_q;
    logic [MapW-1:0]       shadow_map_q, active_map_q;
    logic [NoSlvPorts-1:0] shadow_en_q, active_en_q;
    logic [CntW-1:0]       cnt_q [NoSlvPorts];
    logic [CntW-1:0]       cnt_d [NoSlvPorts];
    logic [NoSlvPorts-1:0] underflow, gate, cnt_zero;
    logic                  err_q, done_q, cfg_fire, err_set, wr_rule;
    int                    wr_off;

    function automatic int net_cnt(input logic [CntW-1:0] cnt, input logic aw, input logic ar,
                                   input logic b, input logic r);
        return int'(cnt) + int'(aw) + int'(ar) - int'(b) - int'(r);
    endfunction

    // Clamp at zero on underflow and at the counter ceiling, so the count never wraps.
    function automatic logic [CntW-1:0] sat_cnt(input int v);
        if (v < 0) return '0;
        if (v > CntMax) return CntW'(CntMax);
        return CntW'(v);
    endfunction

    always_comb begin
        for (int i = 0; i < NoSlvPorts; i++) begin
            underflow[i] = net_cnt(cnt_q[i], bus.aw_fire_i[i], bus.ar_fire_i[i],
                                   bus.b_fire_i[i], bus.r_last_fire_i[i]) < 0;
            cnt_d[i]     = sat_cnt(net_cnt(cnt_q[i], bus.aw_fire_i[i], bus.ar_fire_i[i],
                                           bus.b_fire_i[i], bus.r_last_fire_i[i]));
            gate[i]      = (state_q != IDLE) || (cnt_q[i] > GateThr);
            cnt_zero[i]  = (cnt_q[i] == '0);
        end
    end

    // Rule word layout is {idx, start, end}; sub-words 5..7 of each rule slot are holes.
    always_comb begin
        wr_rule = 1'b0;
        wr_off  = 0;
        if (bus.cfg_addr_i < MaskAddr) begin
            wr_rule = 1'b1;
            case (bus.cfg_addr_i[2:0])
                3'd0:    wr_off = 128;
                3'd1:    wr_off = 64;
                3'd2:    wr_off = 96;
                3'd3:    wr_off = 0;
                3'd4:    wr_off = 32;
                default: wr_rule = 1'b0;
            endcase
            wr_off = wr_off + int'(bus.cfg_addr_i[15:3]) * RuleW;
        end
    end

    assign cfg_fire = bus.cfg_valid_i && (state_q == IDLE);
    assign err_set  = (|underflow) || (|((bus.aw_fire_i | bus.ar_fire_i) & gate));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            shadow_map_q <= '0;
            active_map_q <= '0;
            shadow_en_q  <= '0;
            active_en_q  <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NoSlvPorts; i++) cnt_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (err_set) err_q <= 1'b1;
            for (int i = 0; i < NoSlvPorts; i++) cnt_q[i] <= cnt_d[i];
            case (state_q)
                IDLE: begin
                    if (cfg_fire) begin
                        if (wr_rule) shadow_map_q[wr_off +: 32] <= bus.cfg_wdata_i;
                        else if (bus.cfg_addr_i == MaskAddr)
                            shadow_en_q <= bus.cfg_wdata_i[NoSlvPorts-1:0];
                        else if (bus.cfg_addr_i == CommitAddr) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((&cnt_zero) && !(|bus.b_fire_i) && !(|bus.r_last_fire_i))
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    active_map_q <= shadow_map_q;
                    active_en_q  <= shadow_en_q;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready_o   = (state_q == IDLE);
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.gate_o        = gate;
    assign bus.addr_map_o    = active_map_q;
    assign bus.en_default_o  = active_en_q;
    assign bus.commit_done_o = done_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_axi_xbar_map_ctrl.sv
// Directed bench for axi_xbar_map_ctrl: register writes, drain/commit timing, counters, errors.
`timescale 1ns/1ps
module tb_axi_xbar_map_ctrl;
    localparam int NoSlvPorts = 2;
    localparam int NoRules    = 4;
    localparam int MaxTxns    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    axi_xbar_map_ctrl_if #(.NoSlvPorts(NoSlvPorts), .NoRules(NoRules)) bus ();

    axi_xbar_map_ctrl #(
        .NoSlvPorts(NoSlvPorts),
        .NoRules   (NoRules),
        .MaxTxns   (MaxTxns)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [15:0] a, input logic [31:0] d);
        bus.cfg_valid_i = 1'b1;
        bus.cfg_addr_i  = a;
        bus.cfg_wdata_i = d;
        step();
        bus.cfg_valid_i = 1'b0;
    endtask

    logic [159:0] rule_a, rule_b;

    initial begin
        rule_a = {32'd1, 64'h1000, 64'h2000};
        rule_b = {32'd2, 64'h1000, 64'h2000};
        bus.cfg_valid_i   = 1'b0;
        bus.cfg_addr_i    = '0;
        bus.cfg_wdata_i   = '0;
        bus.aw_fire_i     = '0;
        bus.ar_fire_i     = '0;
        bus.b_fire_i      = '0;
        bus.r_last_fire_i = '0;

        // 1: reset then idle
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_map",   160'(bus.addr_map_o[159:0]), 160'(0));
        chk("rst_en",    160'(bus.en_default_o), 160'(0));
        chk("rst_gate",  160'(bus.gate_o), 160'(0));
        chk("rst_ready", 160'(bus.cfg_ready_o), 160'(1));
        chk("rst_err",   160'(bus.err_o), 160'(0));
        chk("rst_done",  160'(bus.commit_done_o), 160'(0));

        // 2: program rule0/rule1 and mask, commit with no traffic
        cfg_wr(16'd0, 32'd1);
        cfg_wr(16'd1, 32'h1000);
        cfg_wr(16'd2, 32'h0);
        cfg_wr(16'd3, 32'h2000);
        cfg_wr(16'd4, 32'h0);
        cfg_wr(16'd5, 32'hDEAD_BEEF);
        cfg_wr(16'd8, 32'h0000_ABCD);
        cfg_wr(16'd50, 32'hFFFF_FFFF);
        cfg_wr(16'd32, 32'h3);
        chk("pre_commit_map", bus.addr_map_o[159:0], 160'(0));
        cfg_wr(16'd33, 32'h0);
        chk("t1_busy",  160'(bus.busy_o), 160'(1));
        chk("t1_gate",  160'(bus.gate_o), 160'(2'b11));
        chk("t1_ready", 160'(bus.cfg_ready_o), 160'(0));
        step();
        chk("t2_done", 160'(bus.commit_done_o), 160'(0));
        chk("t2_map",  bus.addr_map_o[159:0], 160'(0));
        step();
        chk("t3_done",  160'(bus.commit_done_o), 160'(1));
        chk("t3_rule0", bus.addr_map_o[159:0], rule_a);
        chk("t3_rule1", bus.addr_map_o[319:160], {32'hABCD, 128'h0});
        chk("t3_en",    160'(bus.en_default_o), 160'(2'b11));
        chk("t3_gate",  160'(bus.gate_o), 160'(0));
        chk("t3_busy",  160'(bus.busy_o), 160'(0));
        step();
        chk("t4_done", 160'(bus.commit_done_o), 160'(0));

        // 3: commit waits for three outstanding AWs on port 0
        cfg_wr(16'd0, 32'd2);
        cfg_wr(16'd32, 32'hFFFF_FFFE);
        bus.aw_fire_i = 2'b01;
        step(); step(); step();
        bus.aw_fire_i = 2'b00;
        cfg_wr(16'd33, 32'h0);
        chk("drain_gate", 160'(bus.gate_o), 160'(2'b11));
        chk("drain_busy", 160'(bus.busy_o), 160'(1));
        step(); step();
        chk("drain_hold", bus.addr_map_o[159:0], rule_a);
        for (int k = 0; k < 3; k++) begin
            bus.b_fire_i = 2'b01;
            step();
            bus.b_fire_i = 2'b00;
            chk($sformatf("b%0d_map", k), bus.addr_map_o[159:0], rule_a);
            chk($sformatf("b%0d_busy", k), 160'(bus.busy_o), 160'(1));
        end
        step();
        chk("drained_done", 160'(bus.commit_done_o), 160'(0));
        chk("drained_map",  bus.addr_map_o[159:0], rule_a);
        step();
        chk("swap_done", 160'(bus.commit_done_o), 160'(1));
        chk("swap_map",  bus.addr_map_o[159:0], rule_b);
        chk("swap_en",   160'(bus.en_default_o), 160'(2'b10));
        chk("swap_err",  160'(bus.err_o), 160'(0));

        // 4: near-full gating on port 1
        bus.ar_fire_i = 2'b10;
        for (int k = 0; k < 6; k++) step();
        chk("ar6_gate", 160'(bus.gate_o), 160'(2'b00));
        step();
        bus.ar_fire_i = 2'b00;
        chk("ar7_gate", 160'(bus.gate_o), 160'(2'b10));
        bus.r_last_fire_i = 2'b10;
        step();
        chk("r1_gate", 160'(bus.gate_o), 160'(2'b00));
        for (int k = 0; k < 6; k++) step();
        bus.r_last_fire_i = 2'b00;
        chk("ar_err", 160'(bus.err_o), 160'(0));

        // 5: same-cycle aw+b keeps count, then underflow on port 1
        bus.aw_fire_i = 2'b01;
        step();
        bus.b_fire_i = 2'b01;
        step();
        bus.aw_fire_i = 2'b00;
        step();
        bus.b_fire_i = 2'b00;
        chk("net0_err", 160'(bus.err_o), 160'(0));
        cfg_wr(16'd33, 32'h0);
        step(); step();
        chk("net0_commit", 160'(bus.commit_done_o), 160'(1));
        bus.b_fire_i = 2'b10;
        step();
        bus.b_fire_i = 2'b00;
        chk("uf_err", 160'(bus.err_o), 160'(1));
        step(); step(); step();
        chk("uf_sticky", 160'(bus.err_o), 160'(1));

        // 6: reset during DRAIN
        bus.aw_fire_i = 2'b01;
        step();
        bus.aw_fire_i = 2'b00;
        cfg_wr(16'd33, 32'h0);
        chk("r_drain_busy", 160'(bus.busy_o), 160'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("r_map",  bus.addr_map_o[159:0], 160'(0));
        chk("r_en",   160'(bus.en_default_o), 160'(0));
        chk("r_gate", 160'(bus.gate_o), 160'(0));
        chk("r_busy", 160'(bus.busy_o), 160'(0));
        chk("r_err",  160'(bus.err_o), 160'(0));
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("r_nodone%0d", k), 160'(bus.commit_done_o), 160'(0));
        end
        chk("r_ready", 160'(bus.cfg_ready_o), 160'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
